// File: rtl/riscv_multicycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences a shared-memory datapath through
// fetch/decode/execute/memory/writeback and aborts memory waits after MAX_WAIT cycles.
module riscv_multicycle_controller #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       neg,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_LINK, S_LUI, S_ILLEGAL
  } state_t;

  state_t        state_r, state_next_s;
  logic [CW-1:0] wait_cnt_r, wait_cnt_next_s;
  logic          waiting_s, timeout_s;
  logic          pc_write_s, ir_write_s, mem_write_s, reg_write_s;
  logic          instr_done_s, illegal_s, bus_error_s;

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_FETCH;
      wait_cnt_r <= '0;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
    end
  end

  // Wait counter only grows while a memory state keeps stalling; a timeout restarts it.
  always_comb begin
    waiting_s = (state_r == S_FETCH) || (state_r == S_MEMREAD) || (state_r == S_MEMWRITE);
    timeout_s = waiting_s && !mem_ready && (wait_cnt_r == WAIT_LAST);
    if (waiting_s && !mem_ready && !timeout_s) begin
      wait_cnt_next_s = wait_cnt_r + CW'(1);
    end else begin
      wait_cnt_next_s = '0;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next_s = state_r;
    pc_write_s   = 1'b0;
    adr_src      = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    imm_src      = 3'b000;
    alu_control  = ALU_ADD;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    bus_error_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (timeout_s) begin
          bus_error_s  = 1'b1;
          state_next_s = S_FETCH;
        end else if (mem_ready) begin
          ir_write_s   = 1'b1;
          pc_write_s   = 1'b1;
          state_next_s = S_DECODE;
        end else begin
          state_next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
          OP_R:              state_next_s = S_EXECR;
          OP_I:              state_next_s = S_EXECI;
          OP_BR:             state_next_s = S_BRANCH;
          OP_JAL:            state_next_s = S_LINK;
          OP_JALR:           state_next_s = S_JALR;
          OP_LUI:            state_next_s = S_LUI;
          default:           state_next_s = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        if (op == OP_LOAD) begin
          imm_src      = 3'b000;
          state_next_s = S_MEMREAD;
        end else begin
          imm_src      = 3'b001;
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (timeout_s) begin
          bus_error_s  = 1'b1;
          state_next_s = S_FETCH;
        end else if (mem_ready) begin
          state_next_s = S_MEMWB;
        end else begin
          state_next_s = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        if (timeout_s) begin
          bus_error_s  = 1'b1;
          state_next_s = S_FETCH;
        end else if (mem_ready) begin
          mem_write_s  = 1'b1;
          instr_done_s = 1'b1;
          state_next_s = S_FETCH;
        end else begin
          mem_write_s  = 1'b1;
          state_next_s = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        case (funct3)
          3'b000:  alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
        state_next_s = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        state_next_s = S_ALUWB;
        case (funct3)
          3'b000:  alu_control = ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: state_next_s = S_ILLEGAL;
        endcase
      end
      S_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 2'b10;
        alu_control  = ALU_SUB;
        instr_done_s = 1'b1;
        state_next_s = S_FETCH;
        case (funct3)
          3'b000:  pc_write_s = zero;
          3'b001:  pc_write_s = !zero;
          3'b100:  pc_write_s = neg;
          3'b101:  pc_write_s = !neg;
          default: illegal_s  = 1'b1;
        endcase
      end
      S_JALR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        state_next_s = S_LINK;
      end
      // PC takes the target held in alu_out while the ALU forms old_pc + 4.
      S_LINK: begin
        pc_write_s   = 1'b1;
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        state_next_s = S_ALUWB;
      end
      S_LUI: begin
        imm_src      = 3'b100;
        result_src   = 2'b11;
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_s    = 1'b1;
        instr_done_s = 1'b1;
        state_next_s = S_FETCH;
      end
      default: state_next_s = S_FETCH;
    endcase
  end

  // Strobes are masked during reset because FETCH strobes follow mem_ready.
  assign pc_write   = pc_write_s   & rst;
  assign ir_write   = ir_write_s   & rst;
  assign mem_write  = mem_write_s  & rst;
  assign reg_write  = reg_write_s  & rst;
  assign instr_done = instr_done_s & rst;
  assign illegal    = illegal_s    & rst;
  assign bus_error  = bus_error_s  & rst;

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Multi-cycle control FSM for the RISC-V core: sequences a shared-memory datapath (one memory port for instruction fetch and data, one ALU reused across cycles) through fetch, decode, execute, memory and writeback.
- Drives every datapath select and strobe each cycle and stalls on a memory ready handshake.
- Sits beside the multi-cycle datapath in the multi-cycle top, replacing the single-cycle combinational controller.

Parameters:
- MAX_WAIT, 15: maximum cycles any memory state waits for mem_ready before aborting. Must be 1..255. Wait counter width is clog2(MAX_WAIT+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU result == 0.
- neg  in  1  signed A < B (valid in BRANCH).
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  PC <= result.
- adr_src  out  1  memory address select: 0 = PC, 1 = alu_out.
- ir_write  out  1  latch instruction and old_pc.
- mem_write  out  1  store strobe.
- reg_write  out  1  register file write strobe.
- result_src  out  2  result select: 00 alu_out, 01 read data, 10 ALU result, 11 immediate.
- alu_src_a  out  2  ALU A select: 00 PC, 01 old_pc, 10 rs1 register.
- alu_src_b  out  2  ALU B select: 00 rs2 register, 01 immediate, 10 constant 4.
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
- alu_control  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal  out  1  one-cycle pulse when an unsupported encoding is decoded.
- bus_error  out  1  one-cycle pulse when a memory wait times out.

Behaviour:
- Outputs are Moore from state, with the additional inputs listed per state below.
- Any state and any output not listed for it: all strobes 0, selects 00/000, alu_control add.
- Reset (rst=0): state forced to FETCH and wait counter cleared immediately. All strobes (pc_write, ir_write, mem_write, reg_write, instr_done, illegal, bus_error) forced 0 while rst=0, including mid-instruction.
- FETCH: adr_src=0, A=00, B=10, add, result_src=10.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay.
- DECODE: A=01, B=01, add; imm_src=J if op=1101111, else B (branch/jump target goes into alu_out). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> LINK
  - 1100111 -> JALR
  - 0110111 -> LUI
  - anything else -> ILLEGAL
- MEMADR: A=10, B=01, add; imm_src=I for load, S for store. Go to MEMREAD (load) or MEMWRITE (store).
- MEMREAD: adr_src=1. On mem_ready go to MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: adr_src=1; mem_write held 1 until mem_ready, then FETCH.
- EXECR: A=10, B=00; alu_control from funct3/funct7b5:
  - 000 add (sub if funct7b5=1), 001 sll, 010 slt, 100 xor, 101 srl, 110 or, 111 and.
  - Next state ALUWB.
- EXECI: A=10, B=01, imm_src=I; funct3 000 addi, 010 slti, 100 xori, 110 ori, 111 andi.
  - funct3 001/011/101 -> ILLEGAL instead of ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH: A=10, B=00, sub, result_src=00, then FETCH. pc_write=1 iff taken:
  - beq (000): zero
  - bne (001): !zero
  - blt (100): neg
  - bge (101): !neg
  - Other funct3: pc_write=0 and illegal pulses.
- JALR: A=10, B=01, imm_src=I, add (target into alu_out), then LINK.
- LINK: result_src=00, pc_write=1, A=01, B=10, add (old_pc+4 into alu_out), then ALUWB.
- LUI: imm_src=U, result_src=11, reg_write=1, then FETCH.
- ILLEGAL: illegal=1, no register or memory writes, then FETCH.
- instr_done=1 on any cycle whose next state is FETCH, except timeout aborts.
- Wait counter:
  - Counts consecutive cycles in a memory-waiting state (FETCH, MEMREAD, MEMWRITE) with mem_ready=0.
  - Clears when mem_ready=1 or the state changes.
  - When the count reaches MAX_WAIT with mem_ready still 0: bus_error=1 that cycle, all strobes 0, return to FETCH.
  - mem_ready=1 in the same cycle as the count reaching MAX_WAIT completes normally (no error).
- Latency with mem_ready=1 always:
  - lui 3 cycles, beq 3, R/I-ALU 4, sw 4, jal 4, lw 5, jalr 5.
  - Each cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE adds one cycle.

Test Plan:
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB. reg_write only in cycle 4, alu_control=0000 in EXECR, instr_done in cycle 4. Same instruction with f7b5=1 -> alu_control=0001.
- lw with mem_ready low for 3 cycles in MEMREAD -> 8 cycles total, adr_src=1 throughout MEMREAD, result_src=01 and reg_write=1 only in MEMWB.
- sw, mem_ready held 0 for MAX_WAIT=15 cycles in MEMWRITE -> bus_error pulse, mem_write drops, next state FETCH, no instr_done. Repeat with mem_ready=1 on the 15th wait cycle -> normal completion, no bus_error.
- Branches: beq with zero=1 -> pc_write=1 in BRANCH; bne with zero=1 -> pc_write=0; blt with neg=1 -> taken; bge with neg=1 -> not taken; funct3=010 -> illegal pulse, pc_write=0.
- jal then jalr -> jal: FETCH, DECODE (imm_src=011), LINK (pc_write=1), ALUWB (reg_write=1). jalr: FETCH, DECODE, JALR (imm_src=000), LINK, ALUWB.
- Reset: rst=0 asserted in MEMWB -> reg_write drops to 0 immediately, state FETCH. Release rst with mem_ready=1 -> ir_write=1 on the first clock. Unknown op 1111111 -> ILLEGAL, illegal pulse, no writes.
